// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: prescaled digit scan, frame-latched
// shadow registers, PWM brightness, leading-zero suppression, registered outputs.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned PRESCALE   = 100000,
  parameter int unsigned BRIGHT_W   = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    lz_en,
  input  logic [BRIGHT_W-1:0]     bright,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp,
  output logic                    slot_tick
);

  localparam int unsigned PCW = $clog2(PRESCALE);
  localparam int unsigned SW  = $clog2(NUM_DIGITS);
  localparam int unsigned ONW = $clog2(PRESCALE + 1) + BRIGHT_W + 1;

  localparam logic [PCW-1:0] PRE_LAST = PCW'(PRESCALE - 1);
  localparam logic [SW-1:0]  SEL_LAST = SW'(NUM_DIGITS - 1);

  logic [PCW-1:0]          r_pre_cnt;
  logic [SW-1:0]           r_sel;
  logic                    r_slot_tick;
  logic [4*NUM_DIGITS-1:0] r_sh_digits;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic [NUM_DIGITS-1:0]   r_sh_blank;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;

  logic                    w_slot_end;
  logic                    w_frame_end;
  logic [ONW-1:0]          w_on_cycles;
  logic [NUM_DIGITS-1:0]   w_nz;
  logic [3:0]              w_nib;
  logic                    w_cur_dp;
  logic                    w_cur_blank;
  logic                    w_lz_sup;
  logic                    w_lit;
  logic [NUM_DIGITS-1:0]   w_an_nxt;
  logic [6:0]              w_seg_nxt;
  logic                    w_dp_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    unique case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      4'hF: hex7 = 7'b0001110;
    endcase
  endfunction

  assign w_slot_end  = en && (r_pre_cnt == PRE_LAST);
  assign w_frame_end = w_slot_end && (r_sel == SEL_LAST);

  // Product is formed at ONW bits so all-ones brightness yields exactly PRESCALE.
  assign w_on_cycles = ((ONW'(bright) + ONW'(1)) * ONW'(PRESCALE)) >> BRIGHT_W;

  always_comb begin
    w_nz = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      w_nz[i] = |r_sh_digits[4*i +: 4];
    end
  end

  // A digit is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    w_nib       = '0;
    w_cur_dp    = 1'b0;
    w_cur_blank = 1'b1;
    w_lz_sup    = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_sel == SW'(i)) begin
        w_nib       = r_sh_digits[4*i +: 4];
        w_cur_dp    = r_sh_dp[i];
        w_cur_blank = r_sh_blank[i];
        w_lz_sup    = lz_en && (i != 0) && ((w_nz >> i) == '0);
      end
    end
  end

  assign w_lit = en && (ONW'(r_pre_cnt) < w_on_cycles) && !w_cur_blank && !w_lz_sup;

  always_comb begin
    w_an_nxt  = '1;
    w_seg_nxt = 7'h7F;
    w_dp_nxt  = 1'b1;
    if (w_lit) begin
      w_seg_nxt = hex7(w_nib);
      w_dp_nxt  = ~w_cur_dp;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (r_sel == SW'(i)) begin
          w_an_nxt[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_cnt <= '0;
      r_sel     <= '0;
    end else if (en) begin
      r_pre_cnt <= w_slot_end ? '0 : r_pre_cnt + PCW'(1);
      if (w_slot_end) begin
        r_sel <= (r_sel == SEL_LAST) ? '0 : r_sel + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_digits <= '0;
      r_sh_dp     <= '0;
      r_sh_blank  <= '1;
    end else if (w_frame_end) begin
      r_sh_digits <= digits;
      r_sh_dp     <= dp_in;
      r_sh_blank  <= blank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_tick <= 1'b0;
      r_an        <= '1;
      r_seg       <= 7'h7F;
      r_dp        <= 1'b1;
    end else begin
      r_slot_tick <= w_slot_end;
      r_an        <= w_an_nxt;
      r_seg       <= w_seg_nxt;
      r_dp        <= w_dp_nxt;
    end
  end

  assign an        = r_an;
  assign seg       = r_seg;
  assign dp        = r_dp;
  assign slot_tick = r_slot_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (4 digits, prescale 4, 2-bit brightness):
// stimulus queues per-edge expectations, monitors compare at sample time.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic        lz_en;
  logic [1:0]  bright;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic        slot_tick;

  seg_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE(4), .BRIGHT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .dp_in(dp_in),
    .blank(blank), .lz_en(lz_en), .bright(bright), .seg(seg), .an(an),
    .dp(dp), .slot_tick(slot_tick)
  );

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [12:0] DARK = {4'hF, 7'h7F, 1'b1, 1'b0};

  typedef struct {
    int          e;
    logic [12:0] v;
    string       nm;
  } exp_t;

  exp_t  q[$];
  string aq[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_one(input int e, input logic [12:0] v, input string nm);
    exp_t x;
    x.e = e; x.v = v; x.nm = nm;
    q.push_back(x);
  endtask

  // One frame of 16 edges from st; optional en-low gap of pl edges before slot index pa.
  task automatic push_frame(input int st, input int nj, input int pa, input int pl,
                            input logic [3:0] lit, input logic [3:0] dpm, input int on,
                            input logic [27:0] sg, input string nm);
    for (int j = 0; j < nj; j++) begin
      int s, p, e;
      logic l, d;
      logic [3:0] a;
      logic [6:0] sv;
      s = j / 4;
      p = j % 4;
      if (j == pa) begin
        for (int k = 0; k < pl; k++) push_one(st + j + k, DARK, {nm, "_gap"});
      end
      e = st + j + ((j >= pa) ? pl : 0);
      l = lit[s] && (p < on);
      a = 4'hF;
      if (l) a[s] = 1'b0;
      sv = l ? sg[7*s +: 7] : 7'h7F;
      d  = l ? ~dpm[s] : 1'b1;
      push_one(e, {a, sv, d, (p == 3)}, nm);
    end
  endtask

  task automatic goto(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  initial begin
    exp_t x;
    logic [12:0] got;
    forever begin
      @(posedge clk);
      #3;
      got = {an, seg, dp, slot_tick};
      while (q.size() > 0 && q[0].e <= cyc) begin
        x = q.pop_front();
        n_cmp++;
        if (x.e != cyc || got !== x.v) begin
          n_bad++;
          $display("FAIL %s edge=%0d/%0d got an=%b seg=%b dp=%b tick=%b exp an=%b seg=%b dp=%b tick=%b",
                   x.nm, x.e, cyc, got[12:9], got[8:2], got[1], got[0],
                   x.v[12:9], x.v[8:2], x.v[1], x.v[0]);
        end
      end
    end
  end

  initial begin
    string nm;
    logic [12:0] got;
    forever begin
      @(negedge rst_n);
      #1;
      if (aq.size() > 0) begin
        nm  = aq.pop_front();
        got = {an, seg, dp, slot_tick};
        n_cmp++;
        if (got !== DARK) begin
          n_bad++;
          $display("FAIL %s got an=%b seg=%b dp=%b tick=%b exp dark", nm,
                   got[12:9], got[8:2], got[1], got[0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d pending=%0d", cyc, q.size());
    $fatal(1, "timeout");
  end

  initial begin
    int r, f;
    rst_n = 1'b0; en = 1'b1; digits = 16'h1A80; dp_in = 4'h0; blank = 4'h0;
    lz_en = 1'b0; bright = 2'd3;
    @(negedge clk);
    push_one(cyc + 1, DARK, "reset_state");
    goto(cyc + 1);
    rst_n = 1'b1;
    r = cyc;

    push_frame(r + 1, 16, 16, 0, 4'h0, 4'h0, 4, '0, "dark_first_frame");
    f = r + 17;
    push_frame(f,      16, 16, 0, 4'hF, 4'h0, 4, {S1, SA, S8, S0}, "frame1_1A80");
    push_frame(f + 16, 16, 16, 0, 4'hF, 4'h0, 4, {S1, SA, S8, S0}, "frame2_1A80");

    f += 32; goto(f - 1); bright = 2'd0;
    push_frame(f, 16, 16, 0, 4'hF, 4'h0, 1, {S1, SA, S8, S0}, "bright0");
    f += 16; goto(f - 1); bright = 2'd1;
    push_frame(f, 16, 16, 0, 4'hF, 4'h0, 2, {S1, SA, S8, S0}, "bright1");

    f += 16; goto(f - 2); digits = 16'h0050;
    goto(f - 1); bright = 2'd3; lz_en = 1'b1;
    push_frame(f, 16, 16, 0, 4'b0011, 4'h0, 4, {S0, S0, S5, S0}, "lz_on");
    f += 16; goto(f - 1); lz_en = 1'b0;
    push_frame(f, 16, 16, 0, 4'hF, 4'h0, 4, {S0, S0, S5, S0}, "lz_off");
    goto(f + 3); digits = 16'h1111;

    f += 16;
    push_frame(f, 16, 16, 0, 4'hF, 4'h0, 4, {S1, S1, S1, S1}, "tear_old");
    goto(f + 9); digits = 16'h2222;
    f += 16;
    push_frame(f, 16, 16, 0, 4'hF, 4'h0, 4, {S2, S2, S2, S2}, "tear_new");
    goto(f + 14); dp_in = 4'b0100; blank = 4'b0001;

    f += 16;
    push_frame(f, 16, 16, 0, 4'b1110, 4'b0100, 4, {S2, S2, S2, S2}, "dp_blank");
    f += 16;
    push_frame(f, 16, 6, 10, 4'b1110, 4'b0100, 4, {S2, S2, S2, S2}, "en_pause");
    goto(f + 5); en = 1'b0;
    goto(f + 15); en = 1'b1;

    f += 26;
    push_frame(f, 6, 16, 0, 4'b1110, 4'b0100, 4, {S2, S2, S2, S2}, "pre_reset");
    goto(f + 5);
    aq.push_back("async_reset");
    rst_n = 1'b0;
    push_one(f + 6, DARK, "reset_mid");
    push_one(f + 7, DARK, "reset_mid");
    dp_in = 4'h0; blank = 4'h0;
    goto(f + 7);
    rst_n = 1'b1;
    r = cyc;
    push_frame(r + 1, 16, 16, 0, 4'h0, 4'h0, 4, '0, "dark_after_reset");
    push_frame(r + 17, 16, 16, 0, 4'hF, 4'h0, 4, {S2, S2, S2, S2}, "post_reset");

    goto(r + 33);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (q.size() != 0 || aq.size() != 0) begin
      n_bad++;
      $display("FAIL leftover got %0d/%0d pending exp 0/0", q.size(), aq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 2..8).
REQ-002 Parameter PRESCALE, default 100000, clk cycles per digit slot (legal >=2).
REQ-003 Parameter BRIGHT_W, default 3, brightness control width (legal 1..4).
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 en  in  1  scan enable; 0 freezes counters and blanks display.
REQ-007 digits  in  4*NUM_DIGITS  hex nibbles; digit i = digits[4i+3:4i], digit 0 rightmost.
REQ-008 dp_in  in  NUM_DIGITS  per-digit decimal point request, active-high.
REQ-009 blank  in  NUM_DIGITS  per-digit force-off, active-high.
REQ-010 lz_en  in  1  leading-zero suppression enable.
REQ-011 bright  in  BRIGHT_W  brightness level, 0 dimmest, all-ones full.
REQ-012 seg  out  7  active-low segments, seg[0]=a .. seg[6]=g.
REQ-013 an  out  NUM_DIGITS  active-low anodes, one-hot-low or all-high.
REQ-014 dp  out  1  active-low decimal point.
REQ-015 slot_tick  out  1  one-cycle pulse on each digit advance.

Function
REQ-016 pre_cnt SHALL count 0..PRESCALE-1 while en=1, wrapping to 0; held when en=0.
REQ-017 sel SHALL advance by 1 (NUM_DIGITS-1 wraps to 0) on cycles where en=1 and pre_cnt=PRESCALE-1; slot_tick=1 exactly on those cycles (registered, so visible the following cycle).
REQ-018 Shadow registers for digits, dp_in and blank SHALL load on the cycle sel wraps NUM_DIGITS-1 -> 0; the display shows only shadow values (no mid-frame tearing).
REQ-019 on_cycles = ((bright+1)*PRESCALE) >> BRIGHT_W, computed at width sufficient for no overflow; bright sampled live.
REQ-020 Digit sel is "lit" when en=1, pre_cnt < on_cycles, shadow blank[sel]=0 and not LZ-suppressed.
REQ-021 LZ-suppressed: lz_en=1, sel>0, and shadow nibbles sel..NUM_DIGITS-1 all zero; digit 0 never suppressed.
REQ-022 When lit: an has bit sel low only, seg = hex decode of shadow nibble sel, dp = ~shadow dp[sel]; otherwise an all ones, seg 7'h7F, dp 1.
REQ-023 Hex decode SHALL be standard active-low: 0->7'b1000000, 1->7'b1111001, 8->7'b0000000, A->7'b0001000, F->7'b0001110, all 16 codes defined.
REQ-024 an/seg/dp SHALL be registered: one clk latency from pre_cnt/sel state to outputs.
REQ-025 en falling: outputs go dark next cycle, pre_cnt/sel hold; en rising: scan resumes from held values.
REQ-026 bright=all-ones SHALL give on_cycles=PRESCALE (100% duty); bright=0 SHALL give >=1 only if PRESCALE>=2^BRIGHT_W, else 0 (digit never lit).

Reset
REQ-027 rst_n=0 SHALL immediately force pre_cnt=0, sel=0, slot_tick=0, an all ones, seg 7'h7F, dp 1, shadow digits 0, shadow dp 0, shadow blank all ones.
REQ-028 First frame after reset SHALL be dark (shadow blank all ones) until first wrap load; assertion mid-slot aborts scan with no glitch beyond async clear.

Verification (NUM_DIGITS=4, PRESCALE=4, BRIGHT_W=2 unless noted)
REQ-029 digits=16'h1A80, blank=0, bright=3, lz_en=0, run 2 frames -> second frame an cycles 1110,1101,1011,0111 each 4 clks, seg 7'b1000000, 7'b0000000, 7'b0001000, 7'b1111001.
REQ-030 bright=0 -> each slot an low 1 clk then high 3 clks; bright=1 -> low 2 clks; slot_tick every 4 clks.
REQ-031 digits=16'h0050, lz_en=1 -> digits 3,2 dark, digit 1 shows 5 (7'b0010010), digit 0 shows 0; lz_en=0 -> all four lit.
REQ-032 change digits 16'h1111->16'h2222 while sel=2 -> remainder of frame shows 1, next frame shows 2 (7'b0100100) on all digits.
REQ-033 dp_in=4'b0100, blank=4'b0001 -> dp=0 only in slot 2, digit 0 slot an all ones; en=0 for 10 clks mid-slot -> an all ones, sel/pre_cnt unchanged, resume correct.
REQ-034 rst_n low mid-frame -> outputs dark same cycle; after release one full dark frame, then normal display.
